mips_pc_sequencer: RTL and testbench

//   Parametrised PC sequencer + run-control for the single-cycle MIPS core: computes next PC
//   (seq/branch/j/jal/jr), holds on stall, pauses on non-exit syscall until a Go edge, and

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_pc_sequencer_if.sv | 40 ++++
 rtl/mips_evt_counter.sv | 27 ++
 rtl/mips_pc_sequencer.sv | 120 ++++++++++++
 tb/tb_mips_pc_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS PC sequencer:
// run states, counter select codes, default exit code.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    PAUSE = 2'b01,
    DONE  = 2'b10
  } run_state_e;

  localparam logic [3:0] CTR_CYC   = 4'd0;
  localparam logic [3:0] CTR_BR    = 4'd1;
  localparam logic [3:0] CTR_JMP   = 4'd2;
  localparam logic [3:0] CTR_STALL = 4'd3;
  localparam logic [3:0] CTR_EXT0  = 4'd4;

  localparam logic [31:0] EXIT_CODE_DEF = 32'h0000_0022;

endpackage

// File: rtl/mips_pc_sequencer_if.sv
// Control/status bundle between decode and the PC sequencer.
// master: drives controls, reads pc/state/counters; slave: sequencer.
interface mips_pc_sequencer_if #(
  parameter int CNT_W   = 32,
  parameter int NUM_EXT = 2
);
  localparam int EW = (NUM_EXT > 0) ? NUM_EXT : 1;

  logic          go;
  logic          stall;
  logic          syscall;
  logic [31:0]   syscall_arg;
  logic          branch_taken;
  logic [31:0]   ext18;
  logic          jmp;
  logic [25:0]   target;
  logic          jr;
  logic [31:0]   jr_addr;
  logic [EW-1:0] ext_evt;
  logic [3:0]    ctr_sel;
  logic [31:0]   pc;
  logic [31:0]   pc_plus_4;
  logic [1:0]    run_state;
  logic [CNT_W-1:0] ctr_data;

  modport master (
    output go, stall, syscall, syscall_arg,
    output branch_taken, ext18, jmp, target,
    output jr, jr_addr, ext_evt, ctr_sel,
    input  pc, pc_plus_4, run_state, ctr_data
  );

  modport slave (
    input  go, stall, syscall, syscall_arg,
    input  branch_taken, ext18, jmp, target,
    input  jr, jr_addr, ext_evt, ctr_sel,
    output pc, pc_plus_4, run_state, ctr_data
  );

endinterface

// File: rtl/mips_evt_counter.sv
// Single event counter: +1 per enabled cycle, wrap or saturate.
// Ports: clk, clr (sync, active-high), en in; cnt out.
module mips_evt_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (!(SATURATE && (&r_cnt))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mips_pc_sequencer.sv
// PC sequencer and run control for the single-cycle MIPS core.
// Ports: clk, clr (sync, active-high); bus (slave): controls in,
// pc/pc_plus_4/run_state/ctr_data out.
module mips_pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXIT_CODE    = EXIT_CODE_DEF,
  parameter int          CNT_W        = 32,
  parameter int          NUM_EXT      = 2,
  parameter bit          SATURATE     = 1'b0
) (
  input logic clk,
  input logic clr,
  mips_pc_sequencer_if.slave bus
);

  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE  = DONE;
  localparam int NC = 4 + NUM_EXT;

  logic [31:0] r_pc;
  logic [1:0]  r_state;
  logic        r_go_q;

  logic [31:0] w_pc_plus_4;
  logic [31:0] w_jmp_pc;
  logic [31:0] w_next_pc;
  logic        w_run;
  logic        w_retire;
  logic        w_go_rise;
  logic        w_exit;

  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_jmp_pc = {w_pc_plus_4[31:28], bus.target, 2'b00};
  assign w_run = (r_state == S_RUN);
  assign w_retire = w_run & ~bus.stall;
  assign w_go_rise = bus.go & ~r_go_q;
  assign w_exit = (bus.syscall_arg == EXIT_CODE);

  always_comb begin
    w_next_pc = w_pc_plus_4;
    if (bus.jr) begin
      w_next_pc = bus.jr_addr;
    end else if (bus.jmp) begin
      w_next_pc = w_jmp_pc;
    end else if (bus.branch_taken) begin
      w_next_pc = w_pc_plus_4 + bus.ext18;
    end
  end

  // A syscall parks the PC on itself; resume skips past it.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pc    <= RESET_VECTOR;
      r_state <= S_RUN;
      r_go_q  <= 1'b0;
    end else begin
      r_go_q <= bus.go;
      case (r_state)
        S_RUN: begin
          if (w_retire) begin
            if (bus.syscall) begin
              r_state <= w_exit ? S_DONE : S_PAUSE;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        S_PAUSE: begin
          if (w_go_rise) begin
            r_state <= S_RUN;
            r_pc    <= w_pc_plus_4;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  logic [NC-1:0]    w_en;
  logic [CNT_W-1:0] w_cnt [NC];

  assign w_en[0] = w_run;
  assign w_en[1] = w_retire & bus.branch_taken
                 & ~bus.jr & ~bus.jmp;
  assign w_en[2] = w_retire & (bus.jmp | bus.jr);
  assign w_en[3] = w_run & bus.stall;

  for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext
    assign w_en[4+k] = bus.ext_evt[k];
  end

  for (genvar c = 0; c < NC; c++) begin : g_ctr
    mips_evt_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ctr (
      .clk (clk),
      .clr (clr),
      .en  (w_en[c]),
      .cnt (w_cnt[c])
    );
  end

  always_comb begin
    bus.ctr_data = '0;
    for (int c = 0; c < NC; c++) begin
      if (bus.ctr_sel == 4'(c)) begin
        bus.ctr_data = w_cnt[c];
      end
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc_plus_4 = w_pc_plus_4;
  assign bus.run_state = r_state;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Testbench for mips_pc_sequencer: directed scenarios plus
// randomized run against a behavioural model.
module tb_mips_pc_sequencer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        clr;
  logic        go;
  logic        stall;
  logic        syscall;
  logic [31:0] syscall_arg;
  logic        branch_taken;
  logic [31:0] ext18;
  logic        jmp;
  logic [25:0] target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [1:0]  ext_evt;
  logic [3:0]  ctr_sel;

  mips_pc_sequencer_if #(.CNT_W(32), .NUM_EXT(2)) u_if ();
  mips_pc_sequencer_if #(.CNT_W(4),  .NUM_EXT(2)) s_if ();
  mips_pc_sequencer_if #(.CNT_W(4),  .NUM_EXT(2)) t_if ();

`define DRV(I) \
  assign I.go = go; \
  assign I.stall = stall; \
  assign I.syscall = syscall; \
  assign I.syscall_arg = syscall_arg; \
  assign I.branch_taken = branch_taken; \
  assign I.ext18 = ext18; \
  assign I.jmp = jmp; \
  assign I.target = target; \
  assign I.jr = jr; \
  assign I.jr_addr = jr_addr; \
  assign I.ext_evt = ext_evt; \
  assign I.ctr_sel = ctr_sel;

  `DRV(u_if)
  `DRV(s_if)
  `DRV(t_if)

  mips_pc_sequencer #(
    .CNT_W(32), .NUM_EXT(2), .SATURATE(1'b0)
  ) u_dut (.clk(clk), .clr(clr), .bus(u_if));

  mips_pc_sequencer #(
    .CNT_W(4), .NUM_EXT(2), .SATURATE(1'b0)
  ) u_wrap (.clk(clk), .clr(clr), .bus(s_if));

  mips_pc_sequencer #(
    .CNT_W(4), .NUM_EXT(2), .SATURATE(1'b1)
  ) u_sat (.clk(clk), .clr(clr), .bus(t_if));

  int checks = 0;
  int errors = 0;

  // Model: 0 RUN, 1 PAUSE, 2 DONE; counters as unbounded counts.
  logic [31:0]     m_pc;
  int              m_st;
  bit              m_goq;
  longint unsigned m_cnt [6];

  task automatic model_step();
    bit          ret;
    logic [31:0] p4;
    ret = (m_st == 0) && !stall;
    p4  = m_pc + 32'd4;
    if (clr) begin
      m_pc = 32'h0; m_st = 0; m_goq = 1'b0;
      for (int c = 0; c < 6; c++) m_cnt[c] = 0;
      return;
    end
    if (m_st == 0) m_cnt[0]++;
    if (ret && branch_taken && !jr && !jmp) m_cnt[1]++;
    if (ret && (jmp || jr)) m_cnt[2]++;
    if (m_st == 0 && stall) m_cnt[3]++;
    if (ext_evt[0]) m_cnt[4]++;
    if (ext_evt[1]) m_cnt[5]++;
    if (m_st == 0 && ret) begin
      if (syscall) m_st = (syscall_arg == 32'h22) ? 2 : 1;
      else if (jr) m_pc = jr_addr;
      else if (jmp) m_pc = {p4[31:28], target, 2'b00};
      else if (branch_taken) m_pc = p4 + ext18;
      else m_pc = p4;
    end else if (m_st == 1 && go && !m_goq) begin
      m_st = 0;
      m_pc = p4;
    end
    m_goq = go;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; syscall = 0; syscall_arg = 0;
    branch_taken = 0; ext18 = 0; jmp = 0;
    target = 0; jr = 0; jr_addr = 0; ext_evt = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    jr = 1; jr_addr = a;
    cycle();
    jr = 0; jr_addr = 0;
  endtask

  task automatic do_clr();
    clr = 1; cycle(); clr = 0;
  endtask

  task automatic test_reset();
    go = 0; idle();
    do_clr(); do_clr();
    checks++;
    if (u_if.pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got %h exp %h", u_if.pc, 32'h0);
    end
    checks++;
    if (u_if.pc_plus_4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_pc4 got %h exp %h", u_if.pc_plus_4, 32'h4);
    end
    checks++;
    if (u_if.run_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state got %b exp 00", u_if.run_state);
    end
    for (int c = 0; c < 6; c++) begin
      ctr_sel = 4'(c); #1;
      checks++;
      if (u_if.ctr_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_ctr%0d got %0d exp 0", c, u_if.ctr_data);
      end
    end
  endtask

  task automatic test_seq();
    logic [31:0] exp_c [6];
    exp_c = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_clr();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (u_if.pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_pc%0d got %h exp %h", i, u_if.pc, 32'(4 * i));
      end
      cycle();
    end
    for (int c = 0; c < 6; c++) begin
      ctr_sel = 4'(c); #1;
      checks++;
      if (u_if.ctr_data !== exp_c[c]) begin
        errors++;
        $display("FAIL seq_ctr%0d got %0d exp %0d", c, u_if.ctr_data, exp_c[c]);
      end
    end
  endtask

  task automatic test_redirect();
    do_clr();
    goto_pc(32'h40);
    branch_taken = 1; ext18 = 32'hFFFF_FFF8;
    cycle();
    checks++;
    if (u_if.pc !== 32'h3C) begin
      errors++;
      $display("FAIL br_back got %h exp %h", u_if.pc, 32'h3C);
    end
    jr = 1; jr_addr = 32'h100;
    cycle();
    idle();
    checks++;
    if (u_if.pc !== 32'h100) begin
      errors++;
      $display("FAIL jr_prio got %h exp %h", u_if.pc, 32'h100);
    end
    ctr_sel = 4'd2; #1;
    checks++;
    if (u_if.ctr_data !== 32'd2) begin
      errors++;
      $display("FAIL jmp_ctr got %0d exp 2", u_if.ctr_data);
    end
    ctr_sel = 4'd1; #1;
    checks++;
    if (u_if.ctr_data !== 32'd1) begin
      errors++;
      $display("FAIL br_ctr got %0d exp 1", u_if.ctr_data);
    end
    goto_pc(32'h1000_0000);
    jmp = 1; target = 26'h000010;
    cycle();
    idle();
    checks++;
    if (u_if.pc !== 32'h1000_0040) begin
      errors++;
      $display("FAIL j_target got %h exp %h", u_if.pc, 32'h1000_0040);
    end
  endtask

  task automatic test_pause();
    logic [31:0] c0;
    do_clr();
    goto_pc(32'h20);
    syscall = 1; syscall_arg = 32'h1;
    cycle();
    idle();
    ctr_sel = 4'd0; #1;
    c0 = u_if.ctr_data;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (u_if.pc !== 32'h20 || u_if.run_state !== 2'b01) begin
        errors++;
        $display("FAIL pause_hold%0d got pc=%h st=%b exp pc=%h st=01", i, u_if.pc, u_if.run_state, 32'h20);
      end
      cycle();
    end
    checks++;
    if (u_if.ctr_data !== c0 || u_if.ctr_data !== 32'(m_cnt[0])) begin
      errors++;
      $display("FAIL pause_cyc got %0d exp %0d", u_if.ctr_data, c0);
    end
    go = 1;
    cycle();
    checks++;
    if (u_if.pc !== 32'h24 || u_if.run_state !== 2'b00) begin
      errors++;
      $display("FAIL resume got pc=%h st=%b exp pc=%h st=00", u_if.pc, u_if.run_state, 32'h24);
    end
    syscall = 1; syscall_arg = 32'h5;
    cycle();
    idle();
    repeat (3) cycle();
    checks++;
    if (u_if.run_state !== 2'b01 || u_if.pc !== 32'h24) begin
      errors++;
      $display("FAIL go_level got pc=%h st=%b exp pc=%h st=01", u_if.pc, u_if.run_state, 32'h24);
    end
    go = 0; cycle();
    go = 1; cycle();
    go = 0;
    checks++;
    if (u_if.run_state !== 2'b00 || u_if.pc !== 32'h28) begin
      errors++;
      $display("FAIL re_edge got pc=%h st=%b exp pc=%h st=00", u_if.pc, u_if.run_state, 32'h28);
    end
  endtask

  task automatic test_exit();
    do_clr();
    goto_pc(32'h80);
    syscall = 1; syscall_arg = 32'h22;
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      go = 1; cycle();
      go = 0; cycle();
      checks++;
      if (u_if.run_state !== 2'b10 || u_if.pc !== 32'h80) begin
        errors++;
        $display("FAIL done_hold%0d got pc=%h st=%b exp pc=%h st=10", i, u_if.pc, u_if.run_state, 32'h80);
      end
    end
    ext_evt = 2'b10;
    repeat (3) cycle();
    ext_evt = 2'b00;
    cycle();
    ctr_sel = 4'd5; #1;
    checks++;
    if (u_if.ctr_data !== 32'd3) begin
      errors++;
      $display("FAIL ext1_ctr got %0d exp 3", u_if.ctr_data);
    end
    ctr_sel = 4'd15; #1;
    checks++;
    if (u_if.ctr_data !== 32'd0) begin
      errors++;
      $display("FAIL sel_oor got %0d exp 0", u_if.ctr_data);
    end
    do_clr();
    checks++;
    if (u_if.run_state !== 2'b00 || u_if.pc !== 32'h0) begin
      errors++;
      $display("FAIL done_clr got pc=%h st=%b exp pc=0 st=00", u_if.pc, u_if.run_state);
    end
  endtask

  task automatic test_stall();
    do_clr();
    goto_pc(32'h200);
    stall = 1; syscall = 1; syscall_arg = 32'h1;
    branch_taken = 1; ext18 = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (u_if.pc !== 32'h200 || u_if.run_state !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold%0d got pc=%h st=%b exp pc=%h st=00", i, u_if.pc, u_if.run_state, 32'h200);
      end
    end
    ctr_sel = 4'd3; #1;
    checks++;
    if (u_if.ctr_data !== 32'd3) begin
      errors++;
      $display("FAIL stall_ctr got %0d exp 3", u_if.ctr_data);
    end
    stall = 0;
    cycle();
    idle();
    checks++;
    if (u_if.pc !== 32'h200 || u_if.run_state !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got pc=%h st=%b exp pc=%h st=01", u_if.pc, u_if.run_state, 32'h200);
    end
  endtask

  task automatic test_counters();
    go = 0; idle();
    do_clr();
    repeat (17) cycle();
    ctr_sel = 4'd0; #1;
    checks++;
    if (s_if.ctr_data !== 4'd1) begin
      errors++;
      $display("FAIL cnt_wrap got %0d exp 1", s_if.ctr_data);
    end
    checks++;
    if (t_if.ctr_data !== 4'd15) begin
      errors++;
      $display("FAIL cnt_sat got %0d exp 15", t_if.ctr_data);
    end
    checks++;
    if (u_if.ctr_data !== 32'd17) begin
      errors++;
      $display("FAIL cnt_wide got %0d exp 17", u_if.ctr_data);
    end
  endtask

  task automatic test_random();
    int          sel;
    logic [31:0] exp_d;
    logic [3:0]  exp_w;
    logic [3:0]  exp_s;
    do_clr();
    for (int i = 0; i < 400; i++) begin
      clr = (m_st == 2) && ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      syscall = ($urandom_range(0, 11) == 0);
      syscall_arg = ($urandom_range(0, 3) == 0) ? 32'h22 : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) go = ~go;
      branch_taken = 1'($urandom);
      ext18 = $urandom & 32'hFFFF_FFFC;
      jmp = ($urandom_range(0, 5) == 0);
      target = 26'($urandom);
      jr = ($urandom_range(0, 5) == 0);
      jr_addr = $urandom;
      ext_evt = 2'($urandom);
      if (syscall) begin
        branch_taken = 0; jmp = 0; jr = 0;
      end
      cycle();
      clr = 0;
      checks++;
      if (u_if.pc !== m_pc || u_if.pc_plus_4 !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL rnd_pc@%0d got %h/%h exp %h", i, u_if.pc, u_if.pc_plus_4, m_pc);
      end
      checks++;
      if (u_if.run_state !== 2'(m_st)) begin
        errors++;
        $display("FAIL rnd_state@%0d got %b exp %0d", i, u_if.run_state, m_st);
      end
      sel = $urandom_range(0, 7);
      ctr_sel = 4'(sel); #1;
      exp_d = (sel < 6) ? 32'(m_cnt[sel]) : 32'h0;
      checks++;
      if (u_if.ctr_data !== exp_d) begin
        errors++;
        $display("FAIL rnd_ctr%0d@%0d got %0d exp %0d", sel, i, u_if.ctr_data, exp_d);
      end
      if (sel == 0) begin
        exp_w = 4'(m_cnt[0] % 16);
        exp_s = (m_cnt[0] > 15) ? 4'hF : 4'(m_cnt[0]);
        checks++;
        if (s_if.ctr_data !== exp_w || t_if.ctr_data !== exp_s) begin
          errors++;
          $display("FAIL rnd_small@%0d got %0d/%0d exp %0d/%0d", i, s_if.ctr_data, t_if.ctr_data, exp_w, exp_s);
        end
      end
    end
  endtask

  initial begin
    clr = 0; go = 0; ctr_sel = 0;
    idle();
    m_pc = 0; m_st = 0; m_goq = 0;
    for (int c = 0; c < 6; c++) m_cnt[c] = 0;
    @(posedge clk); #1;
    test_reset();
    test_seq();
    test_redirect();
    test_pause();
    test_exit();
    test_stall();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
